// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, functs, ALU codes,
// datapath select encodings and the controller state type.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_A   = 6'b011010;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NE  = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS    = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;
  localparam logic [1:0] SRC_B_RT    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_SEXT  = 2'd2;
  localparam logic [1:0] SRC_B_ZEXT  = 2'd3;

  localparam logic [1:0] PC_SRC_ALU   = 2'd0;
  localparam logic [1:0] PC_SRC_JUMP  = 2'd1;
  localparam logic [1:0] PC_SRC_EXC   = 2'd2;
  localparam logic [1:0] PC_SRC_RESET = 2'd3;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
`ifdef MC_CTRL_EXC_EN
    , ST_TRAP = 3'd6
`endif
  } state_e;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU sub-decoder: picks function code, sign mode and operand
// selects for the current controller state, and flags undefined instructions.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  state_e     state,
  output logic [5:0] alu_fun,
  output logic       alu_sign,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       valid
);

  logic [5:0] ex_fun;
  logic       ex_sign;
  logic [1:0] ex_a;
  logic [1:0] ex_b;

  always_comb begin
    ex_fun  = ALU_ADD;
    ex_sign = 1'b0;
    ex_a    = SRC_A_RS;
    ex_b    = SRC_B_RT;
    valid   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   ex_sign = 1'b1;
          F_ADDU:  ex_fun  = ALU_ADD;
          F_SUB:   begin ex_fun = ALU_SUB; ex_sign = 1'b1; end
          F_SUBU:  ex_fun  = ALU_SUB;
          F_AND:   ex_fun  = ALU_AND;
          F_OR:    ex_fun  = ALU_OR;
          F_XOR:   ex_fun  = ALU_XOR;
          F_NOR:   ex_fun  = ALU_NOR;
          F_SLT:   begin ex_fun = ALU_LT; ex_sign = 1'b1; end
          F_SLTU:  ex_fun  = ALU_LT;
          F_SLL:   begin ex_fun = ALU_SLL; ex_a = SRC_A_SHAMT; end
          F_SRL:   begin ex_fun = ALU_SRL; ex_a = SRC_A_SHAMT; end
          F_SRA:   begin ex_fun = ALU_SRA; ex_a = SRC_A_SHAMT; end
          F_JR:    ex_fun  = ALU_A;
          default: valid   = 1'b0;
        endcase
      end
      // Only bltz (rt=0) is implemented out of the regimm group
      OP_REGIMM: begin ex_fun = ALU_LTZ; ex_sign = 1'b1; valid = (rt == 5'd0); end
      OP_BEQ:    begin ex_fun = ALU_EQ;  ex_sign = 1'b1; end
      OP_BNE:    begin ex_fun = ALU_NE;  ex_sign = 1'b1; end
      OP_BLEZ:   begin ex_fun = ALU_LEZ; ex_sign = 1'b1; end
      OP_BGTZ:   begin ex_fun = ALU_GTZ; ex_sign = 1'b1; end
      OP_ADDI:   begin ex_b = SRC_B_SEXT; ex_sign = 1'b1; end
      OP_ADDIU:  ex_b = SRC_B_SEXT;
      OP_SLTI:   begin ex_fun = ALU_LT; ex_b = SRC_B_SEXT; ex_sign = 1'b1; end
      OP_SLTIU:  begin ex_fun = ALU_LT; ex_b = SRC_B_SEXT; end
      OP_ANDI:   begin ex_fun = ALU_AND; ex_b = SRC_B_ZEXT; end
      OP_ORI:    begin ex_fun = ALU_OR;  ex_b = SRC_B_ZEXT; end
      OP_XORI:   begin ex_fun = ALU_XOR; ex_b = SRC_B_ZEXT; end
      OP_LW, OP_SW: ex_b = SRC_B_SEXT;
      OP_J, OP_JAL: valid = 1'b1;
      default:   valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_fun   = ALU_ADD;
    alu_sign  = 1'b0;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RT;
    case (state)
      ST_FETCH:  alu_src_b = SRC_B_FOUR;
      // Branch target; the datapath applies the <<2 on the immediate path
      ST_DECODE: alu_src_b = SRC_B_SEXT;
      ST_EXEC: begin
        alu_fun   = ex_fun;
        alu_sign  = ex_sign;
        alu_src_a = ex_a;
        alu_src_b = ex_b;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller top: registered state, combinational strobes.
// Optional MC_CTRL_EXC_EN adds the TRAP state and exc_valid output.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_out0,
  input  logic        mem_ready,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        iord,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg
`ifdef MC_CTRL_EXC_EN
  , output logic      exc_valid
`endif
);

  state_e     state_q, state_d;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       instr_valid;
  logic       mem_req_c;
  logic       mem_we_c;
  logic       unused_ok;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  // PC constants are consumed by the datapath; the remaining IR fields too
  assign unused_ok = ^{RESET_PC, EXC_VECTOR, instr[25:21], instr[15:6]};

  mc_alu_dec u_alu_dec (
    .opcode    (opcode),
    .funct     (funct),
    .rt        (rt),
    .state     (state_q),
    .alu_fun   (alu_fun),
    .alu_sign  (alu_sign),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .valid     (instr_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = M2R_ALU;
`ifdef MC_CTRL_EXC_EN
    exc_valid  = 1'b0;
`endif
    case (state_q)
      ST_RESET: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_RESET;
        state_d  = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_J || opcode == OP_JAL) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
          state_d  = ST_FETCH;
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = REG_DST_R31;
            mem_to_reg = M2R_PC;
          end
        end else if (instr_valid) begin
          state_d = ST_EXEC;
        end else begin
`ifdef MC_CTRL_EXC_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_EXEC: begin
        if (is_branch(opcode)) begin
          pc_write = alu_out0;
          state_d  = ST_FETCH;
        end else if (opcode == OP_RTYPE && funct == F_JR) begin
          pc_write = 1'b1;
          state_d  = ST_FETCH;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        mem_we_c  = (opcode == OP_SW);
        if (mem_ready) state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
        mem_to_reg = (opcode == OP_LW) ? M2R_MDR : M2R_ALU;
        state_d    = ST_FETCH;
      end
`ifdef MC_CTRL_EXC_EN
      ST_TRAP: begin
        exc_valid = 1'b1;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_EXC;
        state_d   = ST_FETCH;
      end
`endif
      default: state_d = ST_RESET;
    endcase
  end

  // Suppress memory strobes in any cycle where reset is being sampled low
  assign mem_req = mem_req_c & reset;
  assign mem_we  = mem_we_c & reset;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl: one row per clock cycle with
// hand-computed outputs, plus hand-written trap and reset-in-stall sequences.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_out0;
  logic        mem_ready;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        iord;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        exc_bit;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .alu_out0   (alu_out0),
    .mem_ready  (mem_ready),
    .alu_fun    (alu_fun),
    .alu_sign   (alu_sign),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .iord       (iord),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg)
`ifdef MC_CTRL_EXC_EN
    , .exc_valid (exc_bit)
`endif
  );
`ifndef MC_CTRL_EXC_EN
  assign exc_bit = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        rst;
    logic        rdy;
    logic        z;
    logic [22:0] exp;
  } vec_t;

  vec_t vt[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Instruction words
  localparam logic [31:0] I_ADD  = 32'h012A4020;
  localparam logic [31:0] I_LW   = 32'h8D090004;
  localparam logic [31:0] I_SW   = 32'hAD090004;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_JR   = 32'h01000008;
  localparam logic [31:0] I_SRA  = 32'h00094083;
  localparam logic [31:0] I_ORI  = 32'h35290005;
  localparam logic [31:0] I_BLTZ = 32'h05000002;
  localparam logic [31:0] I_UND  = 32'hFC000000;

  function automatic logic [22:0] eo(input logic [5:0] f, input logic s,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic io, input logic rq, input logic we,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] m2r);
    return {f, s, a, b, io, rq, we, irw, pcw, pcs, rw, rd, m2r};
  endfunction

  task automatic add_v(input string nm, input logic [31:0] ins, input logic rst,
                       input logic rdy, input logic z, input logic [22:0] e);
    vec_t v;
    v.name = nm; v.ins = ins; v.rst = rst; v.rdy = rdy; v.z = z; v.exp = e;
    vt.push_back(v);
  endtask

  // Apply inputs on the falling edge, check combinational outputs 1ns later
  task automatic step(input string nm, input logic [31:0] ins, input logic rst,
                      input logic rdy, input logic z, input logic [22:0] e, input logic ex);
    logic [23:0] act, want;
    @(negedge clk);
    instr = ins; reset = rst; mem_ready = rdy; alu_out0 = z;
    #1;
    act  = {alu_fun, alu_sign, alu_src_a, alu_src_b, iord, mem_req, mem_we, ir_write,
            pc_write, pc_src, reg_write, reg_dst, mem_to_reg, exc_bit};
    want = {e, ex};
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", nm, act, want);
    end else begin
      $display("ok   %s: outputs %06h", nm, act);
    end
  endtask

  logic [22:0] e_rst, e_fst, e_frd, e_dec, e_mem;

  initial begin
    e_rst = eo(6'b000000, 0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 0, 0, 0);
    e_fst = eo(6'b000000, 0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0);
    e_frd = eo(6'b000000, 0, 0, 1, 0, 1, 0, 1, 1, 2'd0, 0, 0, 0);
    e_dec = eo(6'b000000, 0, 0, 2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    e_mem = eo(6'b000000, 0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 0, 0, 0);

    add_v("reset_c2", I_ADD, 0, 1, 0, e_rst);
    add_v("reset_c3", I_ADD, 0, 0, 0, e_rst);
    add_v("reset_rel", I_ADD, 1, 0, 0, e_rst);
    add_v("add_fetch", I_ADD, 1, 1, 0, e_frd);
    add_v("add_dec", I_ADD, 1, 1, 0, e_dec);
    add_v("add_exec", I_ADD, 1, 1, 0, eo(6'b000000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_v("add_wb", I_ADD, 1, 0, 0, eo(6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    add_v("lw_fetch", I_LW, 1, 1, 0, e_frd);
    add_v("lw_dec", I_LW, 1, 0, 0, e_dec);
    add_v("lw_exec", I_LW, 1, 0, 0, eo(6'b000000, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_v("lw_mem_w1", I_LW, 1, 0, 0, e_mem);
    add_v("lw_mem_w2", I_LW, 1, 0, 0, e_mem);
    add_v("lw_mem_rdy", I_LW, 1, 1, 0, e_mem);
    add_v("lw_wb", I_LW, 1, 0, 0, eo(6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    add_v("beq_fetch", I_BEQ, 1, 1, 0, e_frd);
    add_v("beq_dec", I_BEQ, 1, 0, 0, e_dec);
    add_v("beq_exec_t", I_BEQ, 1, 0, 1, eo(6'b110011, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add_v("beq2_fetch", I_BEQ, 1, 1, 0, e_frd);
    add_v("beq2_dec", I_BEQ, 1, 0, 0, e_dec);
    add_v("beq_exec_nt", I_BEQ, 1, 1, 0, eo(6'b110011, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_v("j_fetch", I_J, 1, 1, 0, e_frd);
    add_v("j_dec", I_J, 1, 0, 0, eo(6'b000000, 0, 0, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    add_v("jal_fetch", I_JAL, 1, 1, 0, e_frd);
    add_v("jal_dec", I_JAL, 1, 0, 0, eo(6'b000000, 0, 0, 2, 0, 0, 0, 0, 1, 1, 1, 2, 2));
    add_v("jr_fetch", I_JR, 1, 1, 0, e_frd);
    add_v("jr_dec", I_JR, 1, 0, 0, e_dec);
    add_v("jr_exec", I_JR, 1, 0, 0, eo(6'b011010, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add_v("sra_fetch", I_SRA, 1, 1, 0, e_frd);
    add_v("sra_dec", I_SRA, 1, 0, 0, e_dec);
    add_v("sra_exec", I_SRA, 1, 0, 0, eo(6'b100011, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_v("sra_wb", I_SRA, 1, 0, 0, eo(6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    add_v("ori_fetch", I_ORI, 1, 1, 0, e_frd);
    add_v("ori_dec", I_ORI, 1, 0, 0, e_dec);
    add_v("ori_exec", I_ORI, 1, 0, 0, eo(6'b011110, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_v("ori_wb", I_ORI, 1, 0, 0, eo(6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add_v("bltz_stall", I_BLTZ, 1, 0, 0, e_fst);
    add_v("bltz_fetch", I_BLTZ, 1, 1, 0, e_frd);
    add_v("bltz_dec", I_BLTZ, 1, 0, 0, e_dec);
    add_v("bltz_exec", I_BLTZ, 1, 0, 1, eo(6'b111011, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add_v("idle_fetch", I_BLTZ, 1, 0, 0, e_fst);

    instr = I_ADD; reset = 1'b0; mem_ready = 1'b0; alu_out0 = 1'b0;
    @(posedge clk);

    foreach (vt[i]) step(vt[i].name, vt[i].ins, vt[i].rst, vt[i].rdy, vt[i].z, vt[i].exp, 1'b0);

    // Undefined opcode 0x3F
    step("und_fetch", I_UND, 1, 1, 0, e_frd, 1'b0);
    step("und_dec", I_UND, 1, 0, 0, e_dec, 1'b0);
`ifdef MC_CTRL_EXC_EN
    step("und_trap", I_UND, 1, 0, 0, eo(6'b000000, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0), 1'b1);
`endif
    step("und_back", I_UND, 1, 0, 0, e_fst, 1'b0);

    // sw with reset dropped in the middle of a MEM stall
    step("sw_fetch", I_SW, 1, 1, 0, e_frd, 1'b0);
    step("sw_dec", I_SW, 1, 0, 0, e_dec, 1'b0);
    step("sw_exec", I_SW, 1, 0, 0, eo(6'b000000, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step("sw_mem_w", I_SW, 1, 0, 0, eo(6'b000000, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    step("sw_mem_rst", I_SW, 0, 1, 0, eo(6'b000000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step("sw_reset", I_SW, 0, 1, 0, e_rst, 1'b0);
    step("sw_rel", I_SW, 1, 1, 0, e_rst, 1'b0);

    // sw zero wait completes in four cycles
    step("sw2_fetch", I_SW, 1, 1, 0, e_frd, 1'b0);
    step("sw2_dec", I_SW, 1, 1, 0, e_dec, 1'b0);
    step("sw2_exec", I_SW, 1, 1, 0, eo(6'b000000, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step("sw2_mem", I_SW, 1, 1, 0, eo(6'b000000, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    step("sw2_next", I_SW, 1, 0, 0, e_fst, 1'b0);
    step("sw2_hold", I_SW, 1, 0, 0, e_fst, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
